// File: rtl/io_timer.sv
// Memory-mapped timer/compare peripheral on LSU I/O page PAGE: prescaled counter,
// compare match with sticky W1C status, auto-reload or one-shot, and level interrupt.
module io_timer #(
    parameter logic [15:0] PAGE = 16'h1002,
    parameter int unsigned PS_W = 16
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_wren,
    input  logic [1:0]  i_lsu_op,
    input  logic        i_ld_un,
    output logic [31:0] o_ld_data,
    output logic        o_irq
);

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_COUNT    = 3'd2,
        REG_COMPARE  = 3'd3,
        REG_STATUS   = 3'd4
    } reg_e;

    logic [2:0]      ctrl;
    logic [PS_W-1:0] prescale;
    logic [31:0]     count;
    logic [31:0]     compare;
    logic            match;
    logic [PS_W-1:0] pc;

    logic        sel;
    logic        wr;
    logic        rd;
    reg_e        idx;
    logic [31:0] cur;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic [31:0] m32;
    logic [31:0] merged;
    logic [31:0] ld_ext;
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic        tick;
    logic        hit;
    logic        wr_ctrl, wr_ps, wr_count, wr_cmp, w1c;
    logic        unused_addr;

    assign sel = (i_lsu_addr[31:16] == PAGE);
    assign wr  = sel & i_lsu_wren;
    assign rd  = sel & ~i_lsu_wren;
    assign idx = reg_e'(i_lsu_addr[4:2]);
    assign unused_addr = ^i_lsu_addr[15:5];

    always_comb begin
        cur = '0;
        case (idx)
            REG_CTRL:     cur = {29'b0, ctrl};
            REG_PRESCALE: cur = 32'(prescale);
            REG_COUNT:    cur = count;
            REG_COMPARE:  cur = compare;
            REG_STATUS:   cur = {31'b0, match};
            default:      cur = '0;
        endcase
    end

    // Store data is replicated across lanes so the byte mask alone picks the target lane.
    always_comb begin
        wdata = i_st_data;
        bmask = 4'hF;
        if (i_lsu_op[1]) begin
            if (!i_lsu_op[0]) begin
                wdata = {2{i_st_data[15:0]}};
                bmask = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
            end else begin
                wdata = {4{i_st_data[7:0]}};
                bmask = 4'b0001 << i_lsu_addr[1:0];
            end
        end
        m32    = {{8{bmask[3]}}, {8{bmask[2]}}, {8{bmask[1]}}, {8{bmask[0]}}};
        merged = (cur & ~m32) | (wdata & m32);
    end

    always_comb begin
        half   = i_lsu_addr[1] ? cur[31:16] : cur[15:0];
        byte_v = cur[7:0];
        case (i_lsu_addr[1:0])
            2'd0: byte_v = cur[7:0];
            2'd1: byte_v = cur[15:8];
            2'd2: byte_v = cur[23:16];
            2'd3: byte_v = cur[31:24];
            default: byte_v = cur[7:0];
        endcase
        if (!i_lsu_op[1])
            ld_ext = cur;
        else if (!i_lsu_op[0])
            ld_ext = {{16{half[15] & ~i_ld_un}}, half};
        else
            ld_ext = {{24{byte_v[7] & ~i_ld_un}}, byte_v};
    end

    assign wr_ctrl  = wr && (idx == REG_CTRL);
    assign wr_ps    = wr && (idx == REG_PRESCALE);
    assign wr_count = wr && (idx == REG_COUNT);
    assign wr_cmp   = wr && (idx == REG_COMPARE);
    assign w1c      = wr && (idx == REG_STATUS) && bmask[0] && wdata[0];

    assign tick = ctrl[0] && (pc == prescale);
    assign hit  = tick && (count == compare);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ctrl      <= '0;
            prescale  <= '0;
            count     <= '0;
            compare   <= '0;
            match     <= 1'b0;
            pc        <= '0;
            o_ld_data <= '0;
        end else begin
            if (wr_ctrl || wr_ps || tick)
                pc <= '0;
            else if (ctrl[0])
                pc <= pc + 1'b1;

            // Software CTRL write overrides the one-shot auto-clear of EN.
            if (wr_ctrl)
                ctrl <= merged[2:0];
            else if (hit && !ctrl[1])
                ctrl[0] <= 1'b0;

            if (wr_ps)
                prescale <= merged[PS_W-1:0];

            if (wr_count)
                count <= merged;
            else if (tick) begin
                if (!hit)
                    count <= count + 1'b1;
                else if (ctrl[1])
                    count <= '0;
            end

            if (wr_cmp)
                compare <= merged;

            if (hit)
                match <= 1'b1;
            else if (w1c)
                match <= 1'b0;

            if (rd)
                o_ld_data <= ld_ext;
        end
    end

    assign o_irq = match & ctrl[2];

endmodule

// File: tb/tb_io_timer.sv
// Directed self-checking bench for io_timer: reset, lanes, periodic, one-shot,
// collisions, wrap, and asynchronous reset with outputs active.
module tb_io_timer;

    localparam logic [31:0] B    = 32'h1002_0000;
    localparam logic [1:0]  OP_W = 2'b00;
    localparam logic [1:0]  OP_H = 2'b10;
    localparam logic [1:0]  OP_B = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] st;
    logic        wren;
    logic [1:0]  op;
    logic        un;
    logic [31:0] ld;
    logic        irq;
    logic [31:0] v;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    io_timer #(.PAGE(16'h1002), .PS_W(16)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_lsu_addr (addr),
        .i_st_data  (st),
        .i_lsu_wren (wren),
        .i_lsu_op   (op),
        .i_ld_un    (un),
        .o_ld_data  (ld),
        .o_irq      (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_cyc(input int n);
        addr = '0; wren = 1'b0; st = '0; op = OP_W; un = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] o);
        addr = a; st = d; wren = 1'b1; op = o; un = 1'b0;
        @(posedge clk); #1;
        addr = '0; wren = 1'b0; st = '0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] o, input logic u, output logic [31:0] d);
        addr = a; wren = 1'b0; op = o; un = u;
        @(posedge clk); #1;
        d = ld;
        addr = '0;
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; st = '0; wren = 1'b0; op = OP_W; un = 1'b0;
        #1;
        check("reset_ld", ld, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cyc(1);

        // Lane extraction and partial stores on COMPARE
        store(B + 32'h0C, 32'h8070_60F0, OP_W);
        load(B + 32'h0C, OP_B, 1'b0, v); check("lb_0c", v, 32'hFFFF_FFF0);
        load(B + 32'h0D, OP_B, 1'b1, v); check("lbu_0d", v, 32'h0000_0060);
        load(B + 32'h0E, OP_H, 1'b0, v); check("lh_0e", v, 32'hFFFF_8070);
        load(B + 32'h0E, OP_H, 1'b1, v); check("lhu_0e", v, 32'h0000_8070);
        store(B + 32'h0F, 32'hFFFF_FF11, OP_B);
        check("hold_on_store", ld, 32'h0000_8070);
        load(32'h1003_000C, OP_W, 1'b0, v); check("hold_other_page", v, 32'h0000_8070);
        load(B + 32'h0C, OP_W, 1'b0, v); check("sb_0f_word", v, 32'h1170_60F0);
        store(B + 32'h0E, 32'h1234_BEEF, OP_H);
        load(B + 32'h0C, OP_W, 1'b0, v); check("sh_0e_word", v, 32'hBEEF_60F0);

        // Periodic: P=3 gives a tick every 4 cycles, match on 3rd tick
        store(B + 32'h04, 32'd3, OP_W);
        store(B + 32'h0C, 32'd2, OP_W);
        store(B + 32'h08, 32'd0, OP_W);
        store(B + 32'h00, 32'h7, OP_W);
        for (int k = 1; k <= 12; k++) begin
            load(B + 32'h08, OP_W, 1'b0, v);
            check("periodic_count", v, 32'((k - 1) / 4));
            check("periodic_irq", {31'b0, irq}, (k == 12) ? 32'h1 : 32'h0);
        end
        load(B + 32'h08, OP_W, 1'b0, v); check("periodic_reload", v, 32'h0);
        load(B + 32'h10, OP_W, 1'b0, v); check("periodic_match", v, 32'h1);
        check("periodic_irq_held", {31'b0, irq}, 32'h1);
        store(B + 32'h10, 32'h1, OP_W);
        check("w1c_irq_drop", {31'b0, irq}, 32'h0);

        // One-shot: P=0, COMPARE=5
        store(B + 32'h00, 32'h0, OP_W);
        store(B + 32'h10, 32'h1, OP_W);
        store(B + 32'h08, 32'h0, OP_W);
        store(B + 32'h04, 32'h0, OP_W);
        store(B + 32'h0C, 32'd5, OP_W);
        store(B + 32'h00, 32'h1, OP_W);
        idle_cyc(4);
        load(B + 32'h08, OP_W, 1'b0, v); check("oneshot_count4", v, 32'd4);
        load(B + 32'h00, OP_W, 1'b0, v); check("oneshot_en_before", v, 32'h1);
        load(B + 32'h00, OP_W, 1'b0, v); check("oneshot_ctrl", v, 32'h0);
        load(B + 32'h08, OP_W, 1'b0, v); check("oneshot_count", v, 32'd5);
        load(B + 32'h10, OP_W, 1'b0, v); check("oneshot_status", v, 32'h1);
        check("oneshot_irq_masked", {31'b0, irq}, 32'h0);
        idle_cyc(20);
        load(B + 32'h08, OP_W, 1'b0, v); check("oneshot_count_hold", v, 32'd5);

        // COUNT store on a tick edge wins
        store(B + 32'h00, 32'h0, OP_W);
        store(B + 32'h08, 32'h0, OP_W);
        store(B + 32'h0C, 32'h0000_FFFF, OP_W);
        store(B + 32'h04, 32'h1, OP_W);
        store(B + 32'h00, 32'h1, OP_W);
        idle_cyc(1);
        store(B + 32'h08, 32'h100, OP_W);
        store(B + 32'h00, 32'h0, OP_W);
        load(B + 32'h08, OP_W, 1'b0, v); check("count_store_vs_tick", v, 32'h100);

        // W1C on the edge of a new match: set wins
        store(B + 32'h10, 32'h1, OP_W);
        store(B + 32'h08, 32'd3, OP_W);
        store(B + 32'h0C, 32'd3, OP_W);
        store(B + 32'h04, 32'h0, OP_W);
        store(B + 32'h00, 32'h1, OP_W);
        store(B + 32'h10, 32'h1, OP_W);
        load(B + 32'h10, OP_W, 1'b0, v); check("w1c_vs_match", v, 32'h1);
        load(B + 32'h08, OP_W, 1'b0, v); check("oneshot_hold3", v, 32'd3);

        // CTRL write on the one-shot clear edge takes the written value
        store(B + 32'h00, 32'h1, OP_W);
        store(B + 32'h00, 32'h3, OP_W);
        load(B + 32'h00, OP_W, 1'b0, v); check("ctrl_vs_autoclear", v, 32'h3);
        store(B + 32'h00, 32'h0, OP_W);

        // Other page store ignored
        store(B + 32'h08, 32'h55, OP_W);
        store(32'h1003_0008, 32'hDEAD_BEEF, OP_W);
        load(B + 32'h08, OP_W, 1'b0, v); check("other_page_store", v, 32'h55);

        // Wrap: 0xFFFF_FFFF -> 0 with no match
        store(B + 32'h04, 32'h0, OP_W);
        store(B + 32'h0C, 32'h10, OP_W);
        store(B + 32'h10, 32'h1, OP_W);
        store(B + 32'h08, 32'hFFFF_FFFF, OP_W);
        store(B + 32'h00, 32'h1, OP_W);
        store(B + 32'h00, 32'h0, OP_W);
        load(B + 32'h08, OP_W, 1'b0, v); check("wrap_count", v, 32'h0);
        load(B + 32'h10, OP_W, 1'b0, v); check("wrap_match", v, 32'h0);

        // Raise irq and load data, then pulse reset between edges
        store(B + 32'h08, 32'h10, OP_W);
        store(B + 32'h00, 32'h5, OP_W);
        idle_cyc(1);
        check("irq_before_reset", {31'b0, irq}, 32'h1);
        load(B + 32'h0C, OP_W, 1'b0, v); check("ld_before_reset", v, 32'h10);
        rst_n = 1'b0;
        #2;
        check("async_reset_ld", ld, 32'h0);
        check("async_reset_irq", {31'b0, irq}, 32'h0);
        #1 rst_n = 1'b1;
        idle_cyc(1);
        for (int r = 0; r < 8; r++) begin
            load(B + 32'(r * 4), OP_W, 1'b0, v);
            check("post_reset_reg", v, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_timer.md
# io_timer

Memory-mapped timer/compare peripheral that responds to the core's load/store unit request signals on I/O page 0x1002_xxxx. It decodes the same address/data/width/sign request the LSU issues, returns registered load data with the same byte/half/word lane and sign-extension rules, and raises a level interrupt on compare match. It sits beside the LSU's I/O register file. Its `o_ld_data` is muxed into the LSU load path when the address page matches.

## Interface
- `PAGE`, 16'h1002, value of `i_lsu_addr[31:16]` that selects this block.
- `PS_W`, 16, prescaler width in bits.
- `i_clk`, input, 1: the single clock. All state changes on the rising edge.
- `i_reset_n`, input, 1: reset, asynchronous and active-low.
- `i_lsu_addr`, input, 32: byte address of the request.
- `i_st_data`, input, 32: store data, right-aligned.
- `i_lsu_wren`, input, 1: 1 means store, 0 means load.
- `i_lsu_op`, input, 2: access width. 0x selects word, 10 selects half, 11 selects byte.
- `i_ld_un`, input, 1: 0 selects sign-extended load, 1 selects zero-extended load.
- `o_ld_data`, output, 32: registered load data.
- `o_irq`, output, 1: interrupt, equal to `STATUS.MATCH & CTRL.IRQ_EN`, driven from registers.

## Operation
- **Select:** the block is selected when `i_lsu_addr[31:16] == PAGE`. The register is chosen by `i_lsu_addr[4:2]`. Address bits [15:5] are ignored.
- **Register map:**
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN. Other bits read 0.
  - 0x04 PRESCALE: bits [PS_W-1:0] hold P. Other bits read 0.
  - 0x08 COUNT: 32-bit.
  - 0x0C COMPARE: 32-bit.
  - 0x10 STATUS: bit0 MATCH, sticky, write-1-to-clear.
  - 0x14 to 0x1C: read 0, writes ignored.
- **Stores:**
  - Word stores replace the whole register.
  - Half stores: `addr[1]` selects bits [15:0] or [31:16]. The data comes from `i_st_data[15:0]`.
  - Byte stores: `addr[1:0]` selects the lane. The data comes from `i_st_data[7:0]`.
  - Lanes that are not written keep their value.
  - STATUS W1C acts only when lane 0 is written and the written bit0 is 1.
- **Loads:**
  - A word load returns the register.
  - Half and byte loads extract the same lane as stores, then sign- or zero-extend per `i_ld_un`.
- **Prescaler:** an internal counter `pc`, PS_W bits wide.
  - While EN=1: if `pc == P`, a tick occurs and `pc` becomes 0. Otherwise `pc` increments.
  - While EN=0: `pc` holds.
  - One tick occurs every P+1 cycles.
- **On a tick:**
  - If COUNT != COMPARE: COUNT increments. It wraps from 0xFFFF_FFFF to 0 with no side effect.
  - If COUNT == COMPARE: MATCH is set. With AUTO_RELOAD=1, COUNT becomes 0. With AUTO_RELOAD=0 (one-shot), COUNT holds and EN is cleared.
- **Simultaneous events:**
  - A software write to COUNT on a tick edge wins over the tick, and `pc` is cleared.
  - A write to PRESCALE or CTRL clears `pc`.
  - A W1C on STATUS on the same edge as a new match leaves MATCH=1 (set wins).
  - A CTRL write on the same edge as a one-shot auto-clear of EN takes the written value.

## Timing
- **Reset:** while `i_reset_n` is 0, all registers, `pc`, `o_ld_data` and `o_irq` are 0 immediately, without waiting for a clock edge. The first tick can occur on the first edge after release, once EN is written.
- **Load latency:** 1 cycle. A load sampled at edge N has its data on `o_ld_data` after edge N. The value returned is the register before any update made at edge N.
- **Hold cases:** `o_ld_data` holds its value on stores, on unselected cycles, and on loads to other pages.
- **Store visibility:** a store sampled at edge N is visible to a load sampled at edge N+1.
- **Interrupt timing:** `o_irq` rises in the cycle after the matching tick edge. It falls in the cycle after the W1C edge, or after the edge that clears IRQ_EN.
- **Handshake:** none. A request is one cycle long. The block never stalls.

## Test plan
- **Reset:** pulse `i_reset_n` low between edges. Expect `o_ld_data`=0 and `o_irq`=0 asynchronously. Word loads of 0x1002_0000 to 0x1002_001C then all return 0.
- **Periodic:** write PRESCALE=3, COMPARE=2, CTRL=0x7.
  - Expect a tick every 4 cycles.
  - On the 3rd tick, MATCH=1 and COUNT=0; `o_irq` rises 1 cycle later.
  - A store of 1 to STATUS drops `o_irq` the next cycle.
- **One-shot:** write PRESCALE=0, COMPARE=5, CTRL=0x1.
  - After 6 ticks, CTRL reads 0, COUNT reads 5, STATUS reads 1.
  - COUNT stays 5 for 20 further cycles.
- **Lanes:** write COMPARE=0x8070_60F0, then check:
  - `lb` at 0x0C returns 0xFFFF_FFF0.
  - `lbu` at 0x0D returns 0x0000_0060.
  - `lh` at 0x0E returns 0xFFFF_8070.
  - `lhu` at 0x0E returns 0x0000_8070.
  - `sb` of 0x11 at 0x0F, then a word load, returns 0x1170_60F0.
- **Collisions:**
  - A COUNT store of 0x100 on a tick edge leaves COUNT reading 0x100.
  - A STATUS W1C on the edge of a new match leaves MATCH=1.
  - A store to 0x1003_0008 leaves COUNT unchanged.
- **Wrap:** write COUNT=0xFFFF_FFFF and COMPARE=0x10, with EN=1 and P=0. The next tick gives COUNT=0 and MATCH=0.
